// File: rtl/interrupt_sequencer_if.sv
// Handshake bundle between the interrupt sequencer and the surrounding pipeline
// (fetch PC mux, ID/EX injection mux, hazard logic).
interface interrupt_sequencer_if;
    logic        INT;
    logic [31:0] Fetch_PC;
    logic        To_PC_Selector;
    logic [31:0] Jump_Target;
    logic        Mem_Busy;
    logic        Rti_Done;

    logic        Stall_Fetch;
    logic        Flush_Decode;
    logic        Inject_Valid;
    logic        Inject_SP;
    logic        Inject_Stack_PC;
    logic        Inject_Stack_Flags;
    logic [31:0] Return_PC;
    logic        PC_Load;
    logic [31:0] PC_Load_Value;
    logic        Int_Active;

    modport master (
        output INT, Fetch_PC, To_PC_Selector, Jump_Target, Mem_Busy, Rti_Done,
        input  Stall_Fetch, Flush_Decode, Inject_Valid, Inject_SP, Inject_Stack_PC,
               Inject_Stack_Flags, Return_PC, PC_Load, PC_Load_Value, Int_Active
    );

    modport slave (
        input  INT, Fetch_PC, To_PC_Selector, Jump_Target, Mem_Busy, Rti_Done,
        output Stall_Fetch, Flush_Decode, Inject_Valid, Inject_SP, Inject_Stack_PC,
               Inject_Stack_Flags, Return_PC, PC_Load, PC_Load_Value, Int_Active
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Hardware-interrupt entry sequencer: drains the pipe, injects PC and flags pushes
// into ID/EX, then redirects fetch to the interrupt vector.
//
// state      | meaning
// IDLE       | normal execution, or inside handler waiting for RTI
// DRAIN      | fetch frozen, decode flushed until drain time elapsed and MEM free
// PUSH_PC    | inject push of Return_PC
// PUSH_FLAGS | inject push of flags
// VECTOR     | load INT_VECTOR into PC
module interrupt_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] INT_VECTOR   = 32'd0
) (
    input logic                  clk,
    input logic                  rst,
    interrupt_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRAIN      = 3'd1,
        PUSH_PC    = 3'd2,
        PUSH_FLAGS = 3'd3,
        VECTOR     = 3'd4
    } state_t;

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

    state_t        state;
    logic          int_d;
    logic          int_pending;
    logic          int_active;
    logic [CW-1:0] drain_cnt;
    logic [31:0]   return_pc;
    logic          stall_fetch;
    logic          flush_decode;
    logic          inject_valid;
    logic          inject_sp;
    logic          inject_stack_pc;
    logic          inject_stack_flags;
    logic          pc_load;
    logic [31:0]   pc_load_value;
    logic          int_rise;

    assign int_rise = bus.INT & ~int_d;

    // Outputs are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            // Track INT through reset so a level held across release is not an edge.
            int_d              <= bus.INT;
            int_pending        <= 1'b0;
            int_active         <= 1'b0;
            drain_cnt          <= '0;
            return_pc          <= '0;
            stall_fetch        <= 1'b0;
            flush_decode       <= 1'b0;
            inject_valid       <= 1'b0;
            inject_sp          <= 1'b0;
            inject_stack_pc    <= 1'b0;
            inject_stack_flags <= 1'b0;
            pc_load            <= 1'b0;
            pc_load_value      <= '0;
        end else begin
            int_d              <= bus.INT;
            stall_fetch        <= 1'b0;
            flush_decode       <= 1'b0;
            inject_valid       <= 1'b0;
            inject_sp          <= 1'b0;
            inject_stack_pc    <= 1'b0;
            inject_stack_flags <= 1'b0;
            pc_load            <= 1'b0;
            pc_load_value      <= '0;
            if (int_rise) begin
                int_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (int_active && bus.Rti_Done) begin
                        int_active <= 1'b0;
                    end
                    if (int_pending && !int_active) begin
                        state        <= DRAIN;
                        return_pc    <= bus.Fetch_PC;
                        drain_cnt    <= CNT_INIT;
                        stall_fetch  <= 1'b1;
                        flush_decode <= 1'b1;
                    end
                end
                DRAIN: begin
                    // A jump resolving during the drain becomes the return address.
                    if (bus.To_PC_Selector) begin
                        return_pc <= bus.Jump_Target;
                    end
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                    if (drain_cnt == '0 && !bus.Mem_Busy) begin
                        state           <= PUSH_PC;
                        stall_fetch     <= 1'b1;
                        inject_valid    <= 1'b1;
                        inject_sp       <= 1'b1;
                        inject_stack_pc <= 1'b1;
                    end else begin
                        stall_fetch  <= 1'b1;
                        flush_decode <= 1'b1;
                    end
                end
                PUSH_PC: begin
                    // An edge arriving on this very cycle is a new request and survives.
                    int_pending        <= int_rise;
                    state              <= PUSH_FLAGS;
                    stall_fetch        <= 1'b1;
                    inject_valid       <= 1'b1;
                    inject_sp          <= 1'b1;
                    inject_stack_flags <= 1'b1;
                end
                PUSH_FLAGS: begin
                    state         <= VECTOR;
                    pc_load       <= 1'b1;
                    pc_load_value <= INT_VECTOR;
                end
                VECTOR: begin
                    state      <= IDLE;
                    int_active <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Stall_Fetch        = stall_fetch;
    assign bus.Flush_Decode       = flush_decode;
    assign bus.Inject_Valid       = inject_valid;
    assign bus.Inject_SP          = inject_sp;
    assign bus.Inject_Stack_PC    = inject_stack_pc;
    assign bus.Inject_Stack_Flags = inject_stack_flags;
    assign bus.Return_PC          = return_pc;
    assign bus.PC_Load            = pc_load;
    assign bus.PC_Load_Value      = pc_load_value;
    assign bus.Int_Active         = int_active;
endmodule
